// File: rtl/edge_counter_multi.sv
// Multi-channel edge counter: synchronised inputs, START/STOP/SNAPSHOT commands, per-channel RTI word emission.
// Build option: define EDGE_COUNTER_SATURATE_EN to make counts saturate with a sticky per-channel flag.
module edge_counter_multi #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rtio_clk,
    input  logic                  rtio_resetn,
    input  logic [NUM_CH-1:0]     input_sig,
    input  logic [63:0]           cmd_in,
    input  logic                  valid,
    input  logic [63:0]           counter,
    input  logic                  wr_full,
    output logic                  write,
    output logic [127:0]          count_out,
    output logic                  busy,
    output logic                  cmd_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_SNAP  = 2'd3;

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]     prev_q;
    logic [DATA_WIDTH-1:0] cnt_q [NUM_CH];
    logic [DATA_WIDTH-1:0] cnt_d [NUM_CH];
    logic [1:0]            mode_q [NUM_CH];
    logic [1:0]            mode_d [NUM_CH];
    logic [NUM_CH-1:0]     run_q, run_d, sat_q, sat_d;
    logic [DATA_WIDTH-1:0] cap_cnt_q [NUM_CH];
    logic [DATA_WIDTH-1:0] cap_cnt_d [NUM_CH];
    logic [NUM_CH-1:0]     cap_run_q, cap_run_d, cap_sat_q, cap_sat_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [63:0]           ts_q, ts_d;
    logic [127:0]          word_q, word_d;
    logic                  word_vld_q, word_vld_d;
    logic                  err_q, err_d;

    logic                  accept_s;
    logic                  fire_s;
    logic [1:0]            op_s, cmd_mode_s;
    logic [NUM_CH-1:0]     mask_s;
    logic [NUM_CH-1:0]     sync_last_s, rise_s, fall_s, hit_s;
    logic [NUM_CH-1:0]     sel_oh_s;
    logic [7:0]            sel_idx_s;
    logic [DATA_WIDTH-1:0] sel_cnt_s;
    logic                  sel_run_s, sel_sat_s;
    logic                  unused_cmd_s;

    function automatic logic [127:0] pack_word(
        input logic [63:0]           ts,
        input logic [7:0]            idx,
        input logic                  sat,
        input logic                  run,
        input logic [DATA_WIDTH-1:0] cnt
    );
        logic [63:0] lo;
        lo                 = 64'd0;
        lo[DATA_WIDTH-1:0] = cnt;
        lo[54]             = run;
        lo[55]             = sat;
        lo[63:56]          = idx;
        return {ts, lo};
    endfunction

    assign op_s         = cmd_in[1:0];
    assign cmd_mode_s   = cmd_in[3:2];
    assign mask_s       = cmd_in[4 +: NUM_CH];
    assign unused_cmd_s = ^cmd_in[63:4+NUM_CH];
    assign accept_s     = valid && (state_q == ST_IDLE);
    assign fire_s       = word_vld_q && !wr_full;

    assign sync_last_s  = sync_q[SYNC_STAGES-1];
    assign rise_s       = sync_last_s & ~prev_q;
    assign fall_s       = ~sync_last_s & prev_q;

    assign write        = fire_s;
    assign count_out    = word_q;
    assign busy         = (state_q == ST_EMIT);
    assign cmd_error    = err_q;

    // Synchroniser chain plus the edge-detect history flop.
    always_ff @(posedge rtio_clk or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= input_sig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_last_s;
        end
    end

    // Per-channel qualifying edge according to the latched edge mode (3 behaves as rising).
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                2'd1:    hit_s[i] = fall_s[i];
                2'd2:    hit_s[i] = rise_s[i] | fall_s[i];
                default: hit_s[i] = rise_s[i];
            endcase
        end
    end

    // Counting and command effects; captures see the count including this cycle's edge.
    always_comb begin
        run_d     = run_q;
        sat_d     = sat_q;
        cap_run_d = cap_run_q;
        cap_sat_d = cap_sat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            mode_d[i]    = mode_q[i];
            cap_cnt_d[i] = cap_cnt_q[i];
            if (run_q[i] && hit_s[i]) begin
`ifdef EDGE_COUNTER_SATURATE_EN
                if (cnt_q[i] == {DATA_WIDTH{1'b1}}) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + DATA_WIDTH'(1);
                end
`else
                cnt_d[i] = cnt_q[i] + DATA_WIDTH'(1);
`endif
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (accept_s && mask_s[i]) begin
                case (op_s)
                    OP_START: begin
                        cnt_d[i]  = '0;
                        mode_d[i] = cmd_mode_s;
                        run_d[i]  = 1'b1;
                        sat_d[i]  = 1'b0;
                    end
                    OP_STOP: begin
                        cap_cnt_d[i] = cnt_d[i];
                        cap_run_d[i] = run_q[i];
                        cap_sat_d[i] = sat_d[i];
                        run_d[i]     = 1'b0;
                    end
                    OP_SNAP: begin
                        cap_cnt_d[i] = cnt_d[i];
                        cap_run_d[i] = run_q[i];
                        cap_sat_d[i] = sat_d[i];
                    end
                    default: begin
                        run_d[i] = run_q[i];
                    end
                endcase
            end else begin
                mode_d[i] = mode_q[i];
            end
        end
    end

    // Channel state and capture registers.
    always_ff @(posedge rtio_clk or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                mode_q[i]    <= 2'd0;
                cap_cnt_q[i] <= '0;
            end
            run_q     <= '0;
            sat_q     <= '0;
            cap_run_q <= '0;
            cap_sat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                mode_q[i]    <= mode_d[i];
                cap_cnt_q[i] <= cap_cnt_d[i];
            end
            run_q     <= run_d;
            sat_q     <= sat_d;
            cap_run_q <= cap_run_d;
            cap_sat_q <= cap_sat_d;
        end
    end

    // Lowest pending channel: isolate the least significant set bit, then mux its capture.
    always_comb begin
        sel_oh_s  = pend_q & (~pend_q + NUM_CH'(1));
        sel_idx_s = 8'd0;
        sel_cnt_s = '0;
        sel_run_s = 1'b0;
        sel_sat_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_idx_s = sel_idx_s | ({8{sel_oh_s[i]}} & 8'(i));
            sel_cnt_s = sel_cnt_s | ({DATA_WIDTH{sel_oh_s[i]}} & cap_cnt_q[i]);
            sel_run_s = sel_run_s | (sel_oh_s[i] & cap_run_q[i]);
            sel_sat_s = sel_sat_s | (sel_oh_s[i] & cap_sat_q[i]);
        end
    end

    // Emission FSM: the staged word is held until the FIFO accepts it.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        ts_d       = ts_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && ((op_s == OP_STOP) || (op_s == OP_SNAP)) && (mask_s != '0)) begin
                    state_d = ST_EMIT;
                    pend_d  = mask_s;
                    ts_d    = counter;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                err_d = valid;
                if (!word_vld_q || fire_s) begin
                    if (pend_q != '0) begin
                        word_d     = pack_word(ts_q, sel_idx_s, sel_sat_s, sel_run_s, sel_cnt_s);
                        word_vld_d = 1'b1;
                        pend_d     = pend_q & ~sel_oh_s;
                    end else begin
                        word_vld_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    word_vld_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_vld_d = 1'b0;
            end
        endcase
    end

    // Emission registers and the dropped-command pulse.
    always_ff @(posedge rtio_clk or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            ts_q       <= 64'd0;
            word_q     <= 128'd0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ts_q       <= ts_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_edge_counter_multi.sv
// Directed bench for edge_counter_multi: vector table of command scenarios plus hand-written corner sequences.
module tb_edge_counter_multi;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   sig;
    logic [63:0]  cmd, ctr;
    logic         vld, full;
    logic         wr, bsy, cerr;
    logic [127:0] cout;
    logic [0:0]   sig4;
    logic [63:0]  cmd4;
    logic         vld4, wr4, bsy4, cerr4;
    logic [127:0] cout4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nerr = 0;
    int full_viol = 0;
    logic [127:0] wq[$];
    int           wc[$];
    logic [127:0] wq4[$];

    typedef struct packed {
        logic [3:0]       st_mask;
        logic [1:0]       st_mode;
        logic [3:0]       npulse;
        logic [1:0]       op;
        logic [3:0]       cap_mask;
        logic [63:0]      ts;
        logic [3:0][15:0] exp_cnt;
        logic [3:0]       exp_run;
    } vec_t;

    vec_t vt [7];

    always #5 clk = ~clk;

    edge_counter_multi #(.NUM_CH(4), .DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .rtio_clk(clk), .rtio_resetn(rstn), .input_sig(sig), .cmd_in(cmd), .valid(vld),
        .counter(ctr), .wr_full(full), .write(wr), .count_out(cout), .busy(bsy), .cmd_error(cerr)
    );

    edge_counter_multi #(.NUM_CH(1), .DATA_WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .rtio_clk(clk), .rtio_resetn(rstn), .input_sig(sig4), .cmd_in(cmd4), .valid(vld4),
        .counter(ctr), .wr_full(1'b0), .write(wr4), .count_out(cout4), .busy(bsy4), .cmd_error(cerr4)
    );

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr) begin
            wq.push_back(cout);
            wc.push_back(cyc);
            if (full) full_viol <= full_viol + 1;
        end
        if (wr4) wq4.push_back(cout4);
        if (cerr) nerr <= nerr + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] s);
        rstn = 1'b0; sig = s; sig4 = 1'b0; vld = 1'b0; vld4 = 1'b0; full = 1'b0;
        cmd = 64'd0; cmd4 = 64'd0;
        step(2);
        rstn = 1'b1;
        step(2);
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] mode, input logic [3:0] mask, input logic [63:0] ts);
        cmd = {56'd0, mask, mode, op};
        ctr = ts;
        vld = 1'b1;
        step(1);
        vld = 1'b0;
        cmd = 64'd0;
    endtask

    task automatic send4(input logic [1:0] op, input logic [63:0] ts);
        cmd4 = {59'd0, 1'b1, 2'd0, op};
        ctr  = ts;
        vld4 = 1'b1;
        step(1);
        vld4 = 1'b0;
        cmd4 = 64'd0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            sig = 4'hF; step(3);
            sig = 4'h0; step(3);
        end
        step(4);
    endtask

    task automatic clearq();
        wq.delete();
        wc.delete();
    endtask

    task automatic check_words(input string tag, input logic [3:0] mask, input logic [63:0] ts,
                               input logic [3:0][15:0] exp_cnt, input logic [3:0] exp_run, input bit consec);
        int k;
        int n;
        logic [127:0] w;
        k = 0;
        n = 0;
        for (int c = 0; c < 4; c++) if (mask[c]) n++;
        chk({tag, ".nwr"}, 64'(wq.size()), 64'(n));
        for (int c = 0; c < 4; c++) begin
            if (mask[c] && (k < wq.size())) begin
                w = wq[k];
                chk({tag, ".idx"}, 64'(w[63:56]), 64'(c));
                chk({tag, ".cnt"}, 64'(w[15:0]), 64'(exp_cnt[c]));
                chk({tag, ".run"}, 64'(w[54]), 64'(exp_run[c]));
                chk({tag, ".ts"}, w[127:64], ts);
                chk({tag, ".rsv"}, 64'({w[55], w[53:16]}), 64'd0);
                if (consec && (k > 0)) chk({tag, ".consec"}, 64'(wc[k] - wc[k-1]), 64'd1);
                k++;
            end
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] st, input logic [1:0] md, input logic [3:0] np, input logic [1:0] op,
                                 input logic [3:0] cm, input logic [63:0] ts, input logic [3:0][15:0] ec, input logic [3:0] er);
        vec_t v;
        v.st_mask = st; v.st_mode = md; v.npulse = np; v.op = op;
        v.cap_mask = cm; v.ts = ts; v.exp_cnt = ec; v.exp_run = er;
        return v;
    endfunction

    initial begin
        int nerr0;
        int drop;
        logic [127:0] w;

        // counts listed {ch3, ch2, ch1, ch0}
        vt[0] = mkv(4'h1, 2'd0, 4'd5, 2'd2, 4'h1, 64'd1000, {16'd0, 16'd0, 16'd0, 16'd5}, 4'b0001);
        vt[1] = mkv(4'hF, 2'd2, 4'd3, 2'd3, 4'hA, 64'd2000, {16'd6, 16'd0, 16'd6, 16'd0}, 4'b1010);
        vt[2] = mkv(4'h5, 2'd1, 4'd4, 2'd2, 4'hF, 64'd77,   {16'd0, 16'd4, 16'd0, 16'd4}, 4'b0101);
        vt[3] = mkv(4'hF, 2'd3, 4'd2, 2'd2, 4'h6, 64'hDEAD_BEEF_0000_0001, {16'd0, 16'd2, 16'd2, 16'd0}, 4'b0110);
        vt[4] = mkv(4'h3, 2'd0, 4'd0, 2'd3, 4'h3, 64'd5,    {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0011);
        vt[5] = mkv(4'h8, 2'd2, 4'd7, 2'd3, 4'h8, 64'd12345, {16'd14, 16'd0, 16'd0, 16'd0}, 4'b1000);
        vt[6] = mkv(4'h1, 2'd0, 4'd1, 2'd2, 4'h0, 64'd9,    {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0000);

        rstn = 1'b0; sig = 4'h0; sig4 = 1'b0; cmd = 64'd0; cmd4 = 64'd0; ctr = 64'd0;
        vld = 1'b0; vld4 = 1'b0; full = 1'b0;
        step(2);
        chk("reset.write", 64'(wr), 64'd0);
        chk("reset.busy", 64'(bsy), 64'd0);
        chk("reset.err", 64'(cerr), 64'd0);
        chk("reset.cout_lo", cout[63:0], 64'd0);
        chk("reset.cout_hi", cout[127:64], 64'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset(4'h0);
            send(2'd1, vt[v].st_mode, vt[v].st_mask, 64'd0);
            pulses(int'(vt[v].npulse));
            clearq();
            send(vt[v].op, 2'd0, vt[v].cap_mask, vt[v].ts);
            step(20);
            check_words($sformatf("vec%0d", v), vt[v].cap_mask, vt[v].ts, vt[v].exp_cnt, vt[v].exp_run, 1'b1);
            chk($sformatf("vec%0d.busy_end", v), 64'(bsy), 64'd0);
        end

        // counting continues after a snapshot
        do_reset(4'h0);
        send(2'd1, 2'd2, 4'hF, 64'd0);
        pulses(3);
        send(2'd3, 2'd0, 4'hA, 64'd2000);
        step(10);
        pulses(2);
        clearq();
        send(2'd3, 2'd0, 4'h2, 64'd3000);
        step(10);
        check_words("cont", 4'h2, 64'd3000, {16'd0, 16'd0, 16'd10, 16'd0}, 4'b0010, 1'b1);

        // back-pressure: FIFO full for 4 cycles after the first write
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'h7, 64'd0);
        pulses(2);
        clearq();
        send(2'd2, 2'd0, 4'h7, 64'd55);
        for (int i = 0; i < 40 && wq.size() == 0; i++) step(1);
        chk("bp.first_write", 64'(wq.size() > 0), 64'd1);
        full = 1'b1;
        drop = 0;
        repeat (4) begin
            step(1);
            if (!bsy) drop++;
        end
        full = 1'b0;
        step(20);
        chk("bp.busy_held", 64'(drop), 64'd0);
        chk("bp.write_while_full", 64'(full_viol), 64'd0);
        check_words("bp", 4'h7, 64'd55, {16'd0, 16'd2, 16'd2, 16'd2}, 4'b0111, 1'b0);
        if (wc.size() >= 3) begin
            chk("bp.gap", 64'(wc[1] - wc[0]), 64'd5);
            chk("bp.tail", 64'(wc[2] - wc[1]), 64'd1);
        end

        // command during emission is dropped with one error pulse
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'hF, 64'd0);
        pulses(1);
        clearq();
        nerr0 = nerr;
        send(2'd2, 2'd0, 4'hF, 64'd9);
        step(1);
        send(2'd1, 2'd0, 4'hF, 64'd0);
        step(20);
        check_words("drop", 4'hF, 64'd9, {16'd1, 16'd1, 16'd1, 16'd1}, 4'b1111, 1'b1);
        chk("drop.err_pulses", 64'(nerr - nerr0), 64'd1);
        clearq();
        send(2'd3, 2'd0, 4'hF, 64'd10);
        step(20);
        check_words("drop.after", 4'hF, 64'd10, {16'd1, 16'd1, 16'd1, 16'd1}, 4'b0000, 1'b1);

        // narrow counter: saturate or wrap after 17 edges
        do_reset(4'h0);
        send4(2'd1, 64'd0);
        repeat (17) begin
            sig4 = 1'b1; step(3);
            sig4 = 1'b0; step(3);
        end
        step(4);
        wq4.delete();
        send4(2'd2, 64'd42);
        step(10);
        chk("sat.nwr", 64'(wq4.size()), 64'd1);
        if (wq4.size() > 0) begin
            w = wq4[0];
`ifdef EDGE_COUNTER_SATURATE_EN
            chk("sat.cnt", 64'(w[15:0]), 64'd15);
            chk("sat.flag", 64'(w[55]), 64'd1);
`else
            chk("sat.cnt", 64'(w[15:0]), 64'd1);
            chk("sat.flag", 64'(w[55]), 64'd0);
`endif
            chk("sat.ts", w[127:64], 64'd42);
        end

        // reset in the middle of an emission
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'hF, 64'd0);
        pulses(1);
        clearq();
        send(2'd2, 2'd0, 4'hF, 64'd99);
        for (int i = 0; i < 40 && wq.size() == 0; i++) step(1);
        chk("rst.first_write", 64'(wq.size()), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rst.write", 64'(wr), 64'd0);
        chk("rst.busy", 64'(bsy), 64'd0);
        chk("rst.cout", 64'(|cout), 64'd0);
        step(2);
        rstn = 1'b1;
        step(20);
        chk("rst.no_more", 64'(wq.size()), 64'd1);
        send(2'd1, 2'd0, 4'h1, 64'd0);
        pulses(2);
        clearq();
        send(2'd2, 2'd0, 4'h1, 64'd321);
        step(20);
        check_words("rst.after", 4'h1, 64'd321, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 1'b1);

        // latency: snapshot one cycle before the edge is counted sees 0
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'h1, 64'd0);
        step(3);
        sig = 4'h1;
        step(1);
        clearq();
        send(2'd3, 2'd0, 4'h1, 64'd1);
        step(10);
        check_words("lat.early", 4'h1, 64'd1, {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0001, 1'b1);

        // latency: snapshot in the counting cycle includes the edge
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'h1, 64'd0);
        step(3);
        sig = 4'h1;
        step(2);
        clearq();
        send(2'd3, 2'd0, 4'h1, 64'd2);
        step(10);
        check_words("lat.exact", 4'h1, 64'd2, {16'd0, 16'd0, 16'd0, 16'd1}, 4'b0001, 1'b1);

        // edge detected in the START cycle is not counted
        do_reset(4'h0);
        send(2'd1, 2'd0, 4'h1, 64'd0);
        step(3);
        sig = 4'h1;
        step(2);
        send(2'd1, 2'd0, 4'h1, 64'd0);
        step(6);
        sig = 4'h0;
        step(3);
        clearq();
        send(2'd3, 2'd0, 4'h1, 64'd3);
        step(10);
        check_words("startcyc", 4'h1, 64'd3, {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0001, 1'b1);

        // inputs high through reset release produce no count
        do_reset(4'hF);
        step(8);
        send(2'd1, 2'd0, 4'hF, 64'd0);
        step(8);
        clearq();
        send(2'd3, 2'd0, 4'hF, 64'd4);
        step(20);
        check_words("hiatrst", 4'hF, 64'd4, {16'd0, 16'd0, 16'd0, 16'd0}, 4'b1111, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_counter_multi.md
EDGE_COUNTER_MULTI -- requirements
Module: edge_counter_multi

Interface
REQ-001 SHALL take parameter NUM_CH, default 4, number of input channels, legal 1..16.
REQ-002 SHALL take parameter DATA_WIDTH, default 16, per-channel count width, legal 1..48.
REQ-003 SHALL take parameter SYNC_STAGES, default 2, input synchroniser depth, legal 2..4.
REQ-004 SHALL have port rtio_clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rtio_resetn, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port input_sig, input, NUM_CH, asynchronous channel inputs.
REQ-007 SHALL have port cmd_in, input, 64, command word from the GPO path.
REQ-008 SHALL have port valid, input, 1, cmd_in qualifier; one-cycle pulse per command.
REQ-009 SHALL have port counter, input, 64, timeline counter.
REQ-010 SHALL have port wr_full, input, 1, downstream RTI FIFO full; stalls emission.
REQ-011 SHALL have port write, output, 1, count_out valid strobe to RTI FIFO.
REQ-012 SHALL have port count_out, output, 128, result word.
REQ-013 SHALL have port busy, output, 1, emission in progress.
REQ-014 SHALL have port cmd_error, output, 1, one-cycle pulse on a dropped command.

Function
REQ-015 SHALL decode cmd_in: [1:0] opcode (0 NOP, 1 START, 2 STOP, 3 SNAPSHOT); [3:2] edge mode (0 rising, 1 falling, 2 both, 3 treated as rising); [4+NUM_CH-1:4] channel mask; other bits ignored.
REQ-016 SHALL accept a command only when valid=1 and state=IDLE; valid=1 in EMIT drops the command and pulses cmd_error the next cycle.
REQ-017 SHALL pass each input_sig bit through SYNC_STAGES flops plus one edge-detect flop; an input transition SHALL increment the count on exactly the (SYNC_STAGES+1)-th clock after first sampling.
REQ-018 START SHALL, per masked channel, clear count to 0, latch edge mode, set running; edges detected in the START cycle SHALL NOT be counted.
REQ-019 While running, a channel SHALL add 1 per qualifying edge; edges on non-running channels SHALL be ignored.
REQ-020 STOP SHALL clear running on masked channels and capture each masked count including any edge detected in the acceptance cycle; SNAPSHOT SHALL capture identically but leave running unchanged.
REQ-021 STOP/SNAPSHOT with nonzero mask SHALL enter EMIT; zero mask, START and NOP SHALL stay IDLE with no write.
REQ-022 In EMIT, SHALL emit one word per masked channel, ascending channel index, at most one per cycle, first write no earlier than the cycle after acceptance.
REQ-023 write SHALL be asserted only in cycles where wr_full=0; while wr_full=1 the pending word SHALL hold and no channel be skipped.
REQ-024 count_out SHALL be: [127:64] counter sampled in the acceptance cycle (same for all words of one command); [63:56] channel index; [55] saturated flag; [54] running-at-capture flag; [DATA_WIDTH-1:0] captured count; others 0.
REQ-025 busy SHALL be 1 from the cycle after acceptance until the cycle after the last write; state SHALL then return to IDLE.
REQ-026 Counting on running channels SHALL continue during EMIT, independent of captured values.

Reset
REQ-027 rtio_resetn=0 SHALL asynchronously clear all counts, running, edge modes, sync and edge flops, capture registers, state to IDLE, and outputs write, count_out, busy, cmd_error to 0.
REQ-028 Reset asserted during EMIT SHALL abort emission; no partial words SHALL appear after release.
REQ-029 Because channels reset not-running, input_sig high at reset release SHALL cause no count.

Configuration
REQ-030 With macro EDGE_COUNTER_SATURATE_EN defined, a count at 2^DATA_WIDTH-1 SHALL hold on further edges and set a sticky per-channel saturated flag, cleared by START or reset.
REQ-031 Without EDGE_COUNTER_SATURATE_EN, counts SHALL wrap modulo 2^DATA_WIDTH and bit [55] SHALL always be 0.

Verification
REQ-032 START mask 0x1 rising, 5 rising pulses on ch0, STOP mask 0x1 at counter=1000 -> one write, count_out[15:0]=5, [63:56]=0, [127:64]=1000, [54]=1.
REQ-033 START mask 0xF both-edges, 3 full pulses on all channels, SNAPSHOT mask 0xA -> two writes in consecutive cycles, ch1 then ch3, count=6 each, [54]=1, channels keep counting.
REQ-034 STOP mask 0x7 with wr_full high 4 cycles after first write -> exactly 3 writes, ch0,ch1,ch2, busy high throughout, no duplicates.
REQ-035 valid pulse during EMIT -> cmd_error pulses once, command has no effect, emission completes unchanged.
REQ-036 DATA_WIDTH=4, 17 rising edges then STOP -> count 15 and [55]=1 with EDGE_COUNTER_SATURATE_EN; count 1 and [55]=0 without.
REQ-037 rtio_resetn low mid-EMIT after first of 4 writes -> outputs 0 immediately, no further writes after release, subsequent START/STOP works normally.
